// File: rtl/bennett_clock_gen_if.sv
// Handshake, configuration and rail outputs of the Bennett clock generator.
// The sequencer drives through master; the generator answers through slave.
interface bennett_clock_gen_if #(
    parameter int WIDTH  = 11,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 16,
    parameter int SW     = $clog2(WIDTH + 1)
);
    logic              start;
    logic [SW-1:0]     cfg_stages;
    logic [HOLD_W-1:0] cfg_hold;
    logic              abort;
    logic              busy;
    logic [2:0]        phase;
    logic [WIDTH-1:0]  active;
    logic [WIDTH-1:0]  clkn;
    logic [WIDTH-1:0]  clkp;
    logic              mclk;
    logic              inst_flag;
    logic              aborted;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, cfg_stages, cfg_hold, abort,
        input  busy, phase, active, clkn, clkp, mclk, inst_flag, aborted, cycle_count
    );

    modport slave (
        input  start, cfg_stages, cfg_hold, abort,
        output busy, phase, active, clkn, clkp, mclk, inst_flag, aborted, cycle_count
    );
endinterface

// File: rtl/bennett_clock_gen.sv
// Thermometer-ramped complementary clock generator for adiabatic ALU stages:
// programmable stage count and top-hold, start/busy handshake, graceful abort.
module bennett_clock_gen #(
    parameter int WIDTH  = 11,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 16,
    parameter int SW     = $clog2(WIDTH + 1)
) (
    input logic               clk,
    input logic               reset,
    bennett_clock_gen_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD      = 3'd2,
        RAMP_DOWN = 3'd3,
        REST      = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     level_reg, level_next;   // popcount of active
    logic [SW-1:0]     stages_reg, stages_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;     // remaining top-hold cycles
    logic              abort_flag_reg, abort_flag_next;
    logic              mclk_reg, mclk_next;
    logic              inst_flag_reg, inst_flag_next;
    logic              aborted_reg, aborted_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [SW-1:0]     stages_clamped;
    logic [WIDTH-1:0]  active_w;

    always_comb begin
        stages_clamped = bus.cfg_stages;
        if (bus.cfg_stages == '0)
            stages_clamped = SW'(1);
        else if (bus.cfg_stages > SW'(WIDTH))
            stages_clamped = SW'(WIDTH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            level_reg      <= '0;
            stages_reg     <= SW'(1);
            hold_reg       <= '0;
            abort_flag_reg <= 1'b0;
            mclk_reg       <= 1'b0;
            inst_flag_reg  <= 1'b0;
            aborted_reg    <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            stages_reg     <= stages_next;
            hold_reg       <= hold_next;
            abort_flag_reg <= abort_flag_next;
            mclk_reg       <= mclk_next;
            inst_flag_reg  <= inst_flag_next;
            aborted_reg    <= aborted_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        level_next      = level_reg;
        stages_next     = stages_reg;
        hold_next       = hold_reg;
        abort_flag_next = abort_flag_reg;
        mclk_next       = mclk_reg;
        inst_flag_next  = 1'b0;
        aborted_next    = 1'b0;
        count_next      = count_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next      = RAMP_UP;
                    level_next      = SW'(1);
                    stages_next     = stages_clamped;
                    hold_next       = bus.cfg_hold;
                    abort_flag_next = 1'b0;
                    mclk_next       = 1'b0;
                end
            end
            RAMP_UP: begin
                if (bus.abort) begin
                    // Release starts from the current height; mclk only if already full.
                    state_next      = RAMP_DOWN;
                    level_next      = level_reg - SW'(1);
                    abort_flag_next = 1'b1;
                    mclk_next       = (level_reg == stages_reg);
                end else if (level_reg == stages_reg) begin
                    mclk_next = 1'b1;
                    if (hold_reg != '0) begin
                        state_next = HOLD;
                    end else begin
                        state_next = RAMP_DOWN;
                        level_next = level_reg - SW'(1);
                    end
                end else begin
                    level_next = level_reg + SW'(1);
                end
            end
            HOLD: begin
                if (bus.abort || hold_reg == HOLD_W'(1)) begin
                    state_next      = RAMP_DOWN;
                    level_next      = level_reg - SW'(1);
                    abort_flag_next = abort_flag_reg | bus.abort;
                end else begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end
            RAMP_DOWN: begin
                if (level_reg == '0) begin
                    state_next     = REST;
                    inst_flag_next = 1'b1;
                    aborted_next   = abort_flag_reg;
                    mclk_next      = 1'b0;
                    count_next     = count_reg + CNT_W'(1);
                end else begin
                    level_next = level_reg - SW'(1);
                end
            end
            REST: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                level_next = '0;
            end
        endcase
    end

    // Rail gi is energised while the ramp height exceeds gi; X marks an unpowered rail.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rail
            assign active_w[gi] = (level_reg > SW'(gi));
            assign bus.clkn[gi] = active_w[gi] ? 1'b0 : 1'bx;
            assign bus.clkp[gi] = active_w[gi] ? 1'b1 : 1'bx;
        end
    endgenerate

    assign bus.active      = active_w;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.phase       = state_reg;
    assign bus.mclk        = mclk_reg;
    assign bus.inst_flag   = inst_flag_reg;
    assign bus.aborted     = aborted_reg;
    assign bus.cycle_count = count_reg;
endmodule
